// File: rtl/seg_link_rx.sv
// seg_link_rx: receiver for the serial seven-segment display link.
// Synchronises shift clock, data, latch enable and clear into clk,
// deserialises 64-bit segment frames, and decodes each accepted frame
// into eight hex digits plus a dot mask. Frames latched with a bit
// count other than 64 are flagged and leave the outputs untouched.
module seg_link_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_clk,
   input  logic             ser_din,
   input  logic             ser_pen,
   input  logic             ser_clrn,
   output logic [63:0]      frame,
   output logic [31:0]      hex_num,
   output logic [7:0]       dots,
   output logic [7:0]       digit_bad,
   output logic             frame_valid,
   output logic             frame_err,
   output logic [CNT_W-1:0] frame_cnt
);

   // Input bundle ordering inside each synchroniser stage.
   localparam int IDX_CLK  = 0;
   localparam int IDX_DIN  = 1;
   localparam int IDX_PEN  = 2;
   localparam int IDX_CLRN = 3;

   // Decodes one wire-level byte {dp,g..a} (active-low) into {bad, nibble}.
   function automatic logic [4:0] decode_byte(input logic [7:0] b);
      logic [6:0] s;
      s = ~b[6:0];
      case (s)
         7'h3F:   decode_byte = {1'b0, 4'h0};
         7'h06:   decode_byte = {1'b0, 4'h1};
         7'h5B:   decode_byte = {1'b0, 4'h2};
         7'h4F:   decode_byte = {1'b0, 4'h3};
         7'h66:   decode_byte = {1'b0, 4'h4};
         7'h6D:   decode_byte = {1'b0, 4'h5};
         7'h7D:   decode_byte = {1'b0, 4'h6};
         7'h07:   decode_byte = {1'b0, 4'h7};
         7'h7F:   decode_byte = {1'b0, 4'h8};
         7'h6F:   decode_byte = {1'b0, 4'h9};
         7'h77:   decode_byte = {1'b0, 4'hA};
         7'h7C:   decode_byte = {1'b0, 4'hB};
         7'h39:   decode_byte = {1'b0, 4'hC};
         7'h5E:   decode_byte = {1'b0, 4'hD};
         7'h79:   decode_byte = {1'b0, 4'hE};
         7'h71:   decode_byte = {1'b0, 4'hF};
         default: decode_byte = {1'b1, 4'h0};
      endcase
   endfunction

   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [1:0]                  hist_q;     // {pen, clk} history for edge detect
   logic [63:0]                 shreg_q, shreg_d;
   logic [6:0]                  bitcnt_q, bitcnt_d;
   logic [63:0]                 frame_q, frame_d;
   logic [31:0]                 hex_q, hex_d;
   logic [7:0]                  dots_q, dots_d;
   logic [7:0]                  bad_q, bad_d;
   logic                        valid_q, valid_d;
   logic                        err_q, err_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;

   logic [3:0]  sync_last_s;
   logic        clk_rise_s;
   logic        pen_rise_s;
   logic        din_s;
   logic        clrn_s;
   logic [63:0] shreg_s;
   logic [6:0]  cnt_s;
   logic [31:0] hex_s;
   logic [7:0]  dots_s;
   logic [7:0]  bad_s;

   assign sync_last_s = sync_q[SYNC_STAGES-1];
   assign clk_rise_s  = sync_last_s[IDX_CLK] & ~hist_q[0];
   assign pen_rise_s  = sync_last_s[IDX_PEN] & ~hist_q[1];
   assign din_s       = sync_last_s[IDX_DIN];
   assign clrn_s      = sync_last_s[IDX_CLRN];

   // Synchroniser chains for the four serial inputs plus edge history.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], {ser_clrn, ser_pen, ser_din, ser_clk}};
         hist_q <= {sync_last_s[IDX_PEN], sync_last_s[IDX_CLK]};
      end
   end

   // Post-shift view: a latch in the same cycle as a shift sees the new bit.
   always_comb begin
      shreg_s = shreg_q;
      cnt_s   = bitcnt_q;
      if (clk_rise_s) begin
         shreg_s = {shreg_q[62:0], din_s};
         cnt_s   = (bitcnt_q == 7'd127) ? 7'd127 : bitcnt_q + 7'd1;
      end else begin
         shreg_s = shreg_q;
         cnt_s   = bitcnt_q;
      end
   end

   // Combinational digit decode of the post-shift register.
   always_comb begin
      hex_s  = 32'h0000_0000;
      dots_s = 8'h00;
      bad_s  = 8'h00;
      for (int k = 0; k < 8; k++) begin
         {bad_s[k], hex_s[4*k +: 4]} = decode_byte(shreg_s[8*k +: 8]);
         dots_s[k] = ~shreg_s[8*k + 7];
      end
   end

   // Next state: clear beats latch; latch accepts only an exact 64-bit count.
   always_comb begin
      shreg_d  = shreg_s;
      bitcnt_d = cnt_s;
      frame_d  = frame_q;
      hex_d    = hex_q;
      dots_d   = dots_q;
      bad_d    = bad_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (!clrn_s) begin
         shreg_d  = 64'h0;
         bitcnt_d = 7'd0;
      end else if (pen_rise_s) begin
         bitcnt_d = 7'd0;
         if (cnt_s == 7'd64) begin
            frame_d = shreg_s;
            hex_d   = hex_s;
            dots_d  = dots_s;
            bad_d   = bad_s;
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         bitcnt_d = cnt_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q  <= 64'h0;
         bitcnt_q <= 7'd0;
         frame_q  <= 64'h0;
         hex_q    <= 32'h0;
         dots_q   <= 8'h00;
         bad_q    <= 8'h00;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         frame_q  <= frame_d;
         hex_q    <= hex_d;
         dots_q   <= dots_d;
         bad_q    <= bad_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign frame       = frame_q;
   assign hex_num     = hex_q;
   assign dots        = dots_q;
   assign digit_bad   = bad_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_seg_link_rx.sv
// Directed bench for seg_link_rx with a scoreboard of expected latch results.
module tb_seg_link_rx;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ser_clk = 1'b0;
   logic          ser_din = 1'b0;
   logic          ser_pen = 1'b0;
   logic          ser_clrn = 1'b1;
   logic [63:0]   frame;
   logic [31:0]   hex_num;
   logic [7:0]    dots;
   logic [7:0]    digit_bad;
   logic          frame_valid;
   logic          frame_err;
   logic [CW-1:0] frame_cnt;

   seg_link_rx #(.SYNC_STAGES(2), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_din(ser_din),
      .ser_pen(ser_pen), .ser_clrn(ser_clrn), .frame(frame),
      .hex_num(hex_num), .dots(dots), .digit_bad(digit_bad),
      .frame_valid(frame_valid), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          is_err;
      logic [63:0]   frm;
      logic [31:0]   hex;
      logic [7:0]    dm;
      logic [7:0]    bad;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   // Model of the last accepted frame.
   logic [63:0]   m_frame = 64'h0;
   logic [31:0]   m_hex = 32'h0;
   logic [7:0]    m_dots = 8'h00;
   logic [7:0]    m_bad = 8'h00;
   logic [CW-1:0] m_cnt = '0;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: seg_of = 7'h3F;  4'h1: seg_of = 7'h06;  4'h2: seg_of = 7'h5B;
         4'h3: seg_of = 7'h4F;  4'h4: seg_of = 7'h66;  4'h5: seg_of = 7'h6D;
         4'h6: seg_of = 7'h7D;  4'h7: seg_of = 7'h07;  4'h8: seg_of = 7'h7F;
         4'h9: seg_of = 7'h6F;  4'hA: seg_of = 7'h77;  4'hB: seg_of = 7'h7C;
         4'hC: seg_of = 7'h39;  4'hD: seg_of = 7'h5E;  4'hE: seg_of = 7'h79;
         default: seg_of = 7'h71;
      endcase
   endfunction

   // Wire-level frame for a hex value and dot mask (active-low segments).
   function automatic logic [63:0] encode(input logic [31:0] v, input logic [7:0] dm);
      logic [63:0] r;
      r = 64'h0;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = {~dm[k], ~seg_of(v[4*k +: 4])};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ser_din = b;
      repeat (2) @(negedge clk);
      ser_clk = 1'b1;
      repeat (4) @(negedge clk);
      ser_clk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bits(input logic [63:0] raw, input int n);
      for (int i = 63; i > 63 - n; i--) send_bit(raw[i]);
   endtask

   task automatic push_valid(input logic [63:0] raw, input logic [31:0] h,
                             input logic [7:0] dm, input logic [7:0] bd);
      exp_t e;
      m_frame = raw; m_hex = h; m_dots = dm; m_bad = bd; m_cnt = m_cnt + 1'b1;
      e = '{1'b0, m_frame, m_hex, m_dots, m_bad, m_cnt};
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e = '{1'b1, m_frame, m_hex, m_dots, m_bad, m_cnt};
      sb.push_back(e);
   endtask

   // Raise pen (caller may have raised ser_clk in the same step), collect pulses.
   task automatic latch_and_check(input string tag);
      int nv, ne;
      exp_t e;
      nv = 0; ne = 0;
      ser_pen = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (frame_valid || frame_err) begin
            chk({tag, "_excl"}, {63'h0, frame_valid & frame_err}, 64'h0);
            if (nv + ne == 0 && sb.size() > 0) begin
               e = sb.pop_front();
               chk({tag, "_kind_err"}, {63'h0, frame_err}, {63'h0, e.is_err});
               chk({tag, "_frame"}, frame, e.frm);
               chk({tag, "_hex"}, {32'h0, hex_num}, {32'h0, e.hex});
               chk({tag, "_dots"}, {56'h0, dots}, {56'h0, e.dm});
               chk({tag, "_bad"}, {56'h0, digit_bad}, {56'h0, e.bad});
               chk({tag, "_cnt"}, {{(64-CW){1'b0}}, frame_cnt}, {{(64-CW){1'b0}}, e.cnt});
            end
            if (frame_valid) nv++;
            if (frame_err) ne++;
         end
      end
      ser_pen = 1'b0;
      ser_clk = 1'b0;
      repeat (4) @(negedge clk);
      chk({tag, "_pulses"}, 64'(nv + ne), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_timeout"}, 64'd0, 64'd1);
      end
   endtask

   initial begin
      logic [63:0] raw;
      logic [31:0] v;
      logic [7:0]  dm;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_frame", frame, 64'h0);
      chk("rst_hex", {32'h0, hex_num}, 64'h0);
      chk("rst_cnt", {{(64-CW){1'b0}}, frame_cnt}, 64'h0);
      chk("rst_pulse", {62'h0, frame_valid, frame_err}, 64'h0);
      repeat (4) @(negedge clk);

      // Basic frame 1234ABCD, dots off.
      raw = encode(32'h1234_ABCD, 8'h00);
      send_bits(raw, 64);
      push_valid(raw, 32'h1234_ABCD, 8'h00, 8'h00);
      latch_and_check("f1");

      // Short frame: 63 bits then latch.
      send_bits(encode(32'h5555_5555, 8'hFF), 63);
      push_err();
      latch_and_check("short63");

      // All zeros.
      raw = encode(32'h0000_0000, 8'h00);
      send_bits(raw, 64);
      push_valid(raw, 32'h0000_0000, 8'h00, 8'h00);
      latch_and_check("zero");

      // Byte 0 has dp on and no segments: undecodable digit.
      raw = encode(32'h7777_7777, 8'h00);
      raw[7:0] = 8'h7F;
      send_bits(raw, 64);
      push_valid(raw, 32'h7777_7770, 8'h01, 8'h01);
      latch_and_check("badbyte");

      // Clear mid-frame, then a full frame.
      send_bits(encode(32'h9876_5432, 8'h3C), 40);
      ser_clrn = 1'b0;
      repeat (5) @(negedge clk);
      ser_clrn = 1'b1;
      repeat (6) @(negedge clk);
      raw = encode(32'hFFFF_FFFF, 8'h00);
      send_bits(raw, 64);
      push_valid(raw, 32'hFFFF_FFFF, 8'h00, 8'h00);
      latch_and_check("clr_ffff");

      // Last shift edge coincident with latch edge.
      raw = encode(32'hCAFE_0915, 8'hA5);
      send_bits(raw, 63);
      ser_din = raw[0];
      repeat (2) @(negedge clk);
      ser_clk = 1'b1;
      push_valid(raw, 32'hCAFE_0915, 8'hA5, 8'h00);
      latch_and_check("coincide");

      // Reset mid-frame.
      send_bits(encode(32'h1111_2222, 8'h00), 30);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_frame = 64'h0; m_hex = 32'h0; m_dots = 8'h00; m_bad = 8'h00; m_cnt = '0;
      chk("mrst_frame", frame, 64'h0);
      chk("mrst_hex", {32'h0, hex_num}, 64'h0);
      chk("mrst_dots", {48'h0, dots, digit_bad}, 64'h0);
      chk("mrst_cnt", {{(64-CW){1'b0}}, frame_cnt}, 64'h0);
      repeat (4) @(negedge clk);
      send_bits(encode(32'h3333_4444, 8'h00), 10);
      push_err();
      latch_and_check("post_rst_err");

      // Counter wrap: 2^CW + 1 frames.
      for (int f = 0; f < (1 << CW) + 1; f++) begin
         v = $urandom;
         dm = 8'($urandom);
         raw = encode(v, dm);
         send_bits(raw, 64);
         push_valid(raw, v, dm, 8'h00);
         latch_and_check("wrap");
      end
      chk("wrap_final", {{(64-CW){1'b0}}, frame_cnt}, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seg_link_rx.md
Name: seg_link_rx

Overview:
- Receiver for the serial seven-segment display link (shift clock, serial data, latch enable, active-low clear) driven by the board display transmitter.
- Deserialises each 64-bit segment frame and decodes it back into an 8-digit hex value plus dot mask.
- Flags malformed frames.
- Used in loopback self-test and simulation to check what the display actually shows against the intended display value.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for all four serial inputs (minimum 2).
- CNT_W, 16, width of the received-frame counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ser_clk  input  1  serial shift clock from the transmitter; asynchronous to clk.
- ser_din  input  1  serial data, MSB first, valid at the ser_clk rising edge.
- ser_pen  input  1  latch/refresh enable; a rising edge ends a frame.
- ser_clrn  input  1  active-low clear of the display shift chain.
- frame  output  64  last accepted raw frame, as wire levels.
- hex_num  output  32  decoded digits; nibble k comes from frame byte k.
- dots  output  8  dots[k] = ~frame[8k+7] (decimal point on).
- digit_bad  output  8  byte k matched no hex pattern; hex_num nibble k forced to 0.
- frame_valid  output  1  one-cycle pulse when frame, hex_num, dots and digit_bad update.
- frame_err  output  1  one-cycle pulse: a latch occurred with bit count ≠ 64.
- frame_cnt  output  CNT_W  number of accepted frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge) clears every register: synchronisers, shift register, bit count and all outputs, which all go to 0.
- Input synchronisation:
  - Each serial input passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - The edge event is sync_last & ~history.
  - Required timing: ser_clk high and low phases each ≥ SYNC_STAGES+1 clk cycles. Narrower pulses may be missed; the bench must not generate them.
- Shift: on a detected ser_clk rising edge:
  - shreg <= {shreg[62:0], din_sync}.
  - bitcnt <= bitcnt+1, saturating at 127.
- Clear: while the synchronised ser_clrn = 0, shreg and bitcnt are held at 0. Clear overrides shift and latch. Outputs retain their last accepted frame.
- Latch: on a detected ser_pen rising edge:
  - If bitcnt = 64: frame <= shreg, decode outputs update, frame_valid=1 for one cycle, frame_cnt += 1.
  - Otherwise: frame_err=1 for one cycle and outputs are unchanged.
  - In both cases bitcnt <= 0 and shreg is kept.
- Same-cycle ser_clk rise and ser_pen rise: the shift happens first and the latch evaluates the post-shift count and data. Exactly 63 prior bits plus this edge is therefore a valid frame.
- Latency: input change first sampled high at clk edge N produces the outputs/pulse visible after edge N+SYNC_STAGES (3 edges for default 2). frame_valid and frame_err are never high together.
- Decode of byte b (wire level; segments active-low; bit order {dp,g,f,e,d,c,b,a}):
  - Let s = ~b[6:0] (active-high g..a).
  - Table (s → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other s gives nibble 0 and digit_bad[k]=1.
  - Decode is combinational from shreg and is registered with frame.
- Bit ordering: the first bit shifted of a 64-bit frame lands in frame[63], so digit 7 (hex_num[31:28]) is transmitted first.
- Reset mid-frame discards partial data. The first frame after reset must be complete to be accepted.
- A latch with no shifts since the previous latch (bitcnt=0) is a frame_err.
- ser_clrn low mid-frame discards partial data. A subsequent latch without 64 new bits is a frame_err.

Test Plan:
- Transmit segments for display value 32'h1234_ABCD with all dots off, then pulse pen → frame_valid once, hex_num=32'h1234ABCD, dots=8'h00, digit_bad=0, frame_cnt=1.
- Send 63 bits then pen → frame_err pulse; frame, hex_num and frame_cnt unchanged. Then a full 64-bit frame of 32'h0000_0000 → hex_num=0, frame_cnt=2.
- Byte 0 = 8'h7F (dp on, all segments off), remaining bytes encode 7 → dots=8'h01, digit_bad=8'h01, hex_num=32'h7777_7770.
- Send 40 bits, drop ser_clrn for 5 cycles, send 64 bits of 32'hFFFF_FFFF and pen → frame_valid with hex_num=32'hFFFFFFFF.
- Final (64th) ser_clk rise coincident with pen rise → accepted frame. Assert rst=1 during a frame → all outputs 0 next edge, and the next partial latch gives frame_err.
- Send 2^CNT_W+1 valid frames (CNT_W overridden to 4) → frame_cnt wraps to 1.
